stg_wb: RTL and testbench

//  Write-back stage, directly downstream of stg_mo. Consumes MO's registered outputs and commits

---
 rtl/stg_wb_if.sv | 54 +++++
 rtl/stg_wb.sv | 84 ++++++++
 tb/tb_stg_wb.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stg_wb_if.sv
// Write-back stage bus: instruction/result fields from MO, register read ports
// for decode, and retirement status.
interface stg_wb_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 48,
  parameter int OPC_W  = 8,
  parameter int GP_AW  = 4,
  parameter int SR_AW  = 2,
  parameter int AR_AW  = 2
);
  logic [ADDR_W-1:0] iw_pc;
  logic [OPC_W-1:0]  iw_opc;
  logic              iw_flush;
  logic [GP_AW-1:0]  iw_tgt_gp;
  logic              iw_tgt_gp_we;
  logic [DATA_W-1:0] iw_result;
  logic [SR_AW-1:0]  iw_tgt_sr;
  logic              iw_tgt_sr_we;
  logic [ADDR_W-1:0] iw_sr_result;
  logic [AR_AW-1:0]  iw_tgt_ar;
  logic              iw_tgt_ar_we;
  logic [ADDR_W-1:0] iw_ar_result;
  logic [GP_AW-1:0]  iw_gp_raddr0;
  logic [GP_AW-1:0]  iw_gp_raddr1;
  logic [SR_AW-1:0]  iw_sr_raddr;
  logic [AR_AW-1:0]  iw_ar_raddr;
  logic [DATA_W-1:0] ow_gp_rdata0;
  logic [DATA_W-1:0] ow_gp_rdata1;
  logic [ADDR_W-1:0] ow_sr_rdata;
  logic [ADDR_W-1:0] ow_ar_rdata;
  logic [ADDR_W-1:0] ow_retired;
  logic [ADDR_W-1:0] ow_last_pc;
  logic              ow_halted;

  modport master (
    output iw_pc, iw_opc, iw_flush,
           iw_tgt_gp, iw_tgt_gp_we, iw_result,
           iw_tgt_sr, iw_tgt_sr_we, iw_sr_result,
           iw_tgt_ar, iw_tgt_ar_we, iw_ar_result,
           iw_gp_raddr0, iw_gp_raddr1, iw_sr_raddr, iw_ar_raddr,
    input  ow_gp_rdata0, ow_gp_rdata1, ow_sr_rdata, ow_ar_rdata,
           ow_retired, ow_last_pc, ow_halted
  );

  modport slave (
    input  iw_pc, iw_opc, iw_flush,
           iw_tgt_gp, iw_tgt_gp_we, iw_result,
           iw_tgt_sr, iw_tgt_sr_we, iw_sr_result,
           iw_tgt_ar, iw_tgt_ar_we, iw_ar_result,
           iw_gp_raddr0, iw_gp_raddr1, iw_sr_raddr, iw_ar_raddr,
    output ow_gp_rdata0, ow_gp_rdata1, ow_sr_rdata, ow_ar_rdata,
           ow_retired, ow_last_pc, ow_halted
  );
endinterface

// File: rtl/stg_wb.sv
// Write-back stage: commits results into GP/SR/AR files, counts retirements,
// and serves decode-stage reads with same-cycle write-through bypass.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   S_RUN    | committing non-NOP, non-flushed instructions
//   S_HALTED | HALT retired; writes/count frozen until reset
module stg_wb #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 48,
  parameter int OPC_W  = 8,
  parameter int GP_AW  = 4,
  parameter int SR_AW  = 2,
  parameter int AR_AW  = 2,
  parameter logic [OPC_W-1:0] OPC_NOP  = '0,
  parameter logic [OPC_W-1:0] OPC_HALT = '1
) (
  input  logic   iw_clk,
  input  logic   iw_rst_n,
  stg_wb_if.slave wb
);
  localparam int GP_N = 2**GP_AW;
  localparam int SR_N = 2**SR_AW;
  localparam int AR_N = 2**AR_AW;

  typedef enum logic {S_RUN, S_HALTED} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] gp_q [GP_N];
  logic [ADDR_W-1:0] sr_q [SR_N];
  logic [ADDR_W-1:0] ar_q [AR_N];
  logic [ADDR_W-1:0] retired_q;
  logic [ADDR_W-1:0] last_pc_q;
  logic              commit;

  assign commit = (state_q == S_RUN) && !wb.iw_flush && (wb.iw_opc != OPC_NOP);

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (commit && (wb.iw_opc == OPC_HALT)) begin
      state_d = S_HALTED;
    end
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      for (int i = 0; i < GP_N; i++) gp_q[i] <= '0;
      for (int i = 0; i < SR_N; i++) sr_q[i] <= '0;
      for (int i = 0; i < AR_N; i++) ar_q[i] <= '0;
      retired_q <= '0;
      last_pc_q <= '0;
    end else if (commit) begin
      if (wb.iw_tgt_gp_we) gp_q[wb.iw_tgt_gp] <= wb.iw_result;
      if (wb.iw_tgt_sr_we) sr_q[wb.iw_tgt_sr] <= wb.iw_sr_result;
      if (wb.iw_tgt_ar_we) ar_q[wb.iw_tgt_ar] <= wb.iw_ar_result;
      retired_q <= retired_q + ADDR_W'(1);
      last_pc_q <= wb.iw_pc;
    end
  end

  // A committing write to the addressed entry wins over the stored value.
  always_comb begin
    wb.ow_gp_rdata0 = gp_q[wb.iw_gp_raddr0];
    wb.ow_gp_rdata1 = gp_q[wb.iw_gp_raddr1];
    wb.ow_sr_rdata  = sr_q[wb.iw_sr_raddr];
    wb.ow_ar_rdata  = ar_q[wb.iw_ar_raddr];
    if (commit && wb.iw_tgt_gp_we && (wb.iw_tgt_gp == wb.iw_gp_raddr0)) wb.ow_gp_rdata0 = wb.iw_result;
    if (commit && wb.iw_tgt_gp_we && (wb.iw_tgt_gp == wb.iw_gp_raddr1)) wb.ow_gp_rdata1 = wb.iw_result;
    if (commit && wb.iw_tgt_sr_we && (wb.iw_tgt_sr == wb.iw_sr_raddr))  wb.ow_sr_rdata  = wb.iw_sr_result;
    if (commit && wb.iw_tgt_ar_we && (wb.iw_tgt_ar == wb.iw_ar_raddr))  wb.ow_ar_rdata  = wb.iw_ar_result;
  end

  assign wb.ow_retired = retired_q;
  assign wb.ow_last_pc = last_pc_q;
  assign wb.ow_halted  = (state_q == S_HALTED);
endmodule

// File: tb/tb_stg_wb.sv
// Bench for stg_wb: directed scenarios plus randomized traffic against a
// behavioural register-file model; a narrow-counter instance covers wrap.
module tb_stg_wb;
  localparam int DW = 24, AW = 48, OW = 8, GW = 4, SW = 2, RW = 2;
  localparam logic [OW-1:0] NOP  = 8'h00;
  localparam logic [OW-1:0] HALT = 8'hFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stg_wb_if #(.DATA_W(DW), .ADDR_W(AW), .OPC_W(OW), .GP_AW(GW), .SR_AW(SW), .AR_AW(RW)) bus ();
  stg_wb_if #(.DATA_W(DW), .ADDR_W(8),  .OPC_W(OW), .GP_AW(GW), .SR_AW(SW), .AR_AW(RW)) sbus ();

  stg_wb #(.DATA_W(DW), .ADDR_W(AW), .OPC_W(OW), .GP_AW(GW), .SR_AW(SW), .AR_AW(RW),
           .OPC_NOP(NOP), .OPC_HALT(HALT))
    dut (.iw_clk(clk), .iw_rst_n(rst_n), .wb(bus));

  stg_wb #(.DATA_W(DW), .ADDR_W(8), .OPC_W(OW), .GP_AW(GW), .SR_AW(SW), .AR_AW(RW),
           .OPC_NOP(NOP), .OPC_HALT(HALT))
    dut_s (.iw_clk(clk), .iw_rst_n(rst_n), .wb(sbus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arrays and a retirement counter.
  logic [DW-1:0] m_gp [16];
  logic [AW-1:0] m_sr [4];
  logic [AW-1:0] m_ar [4];
  logic [AW-1:0] m_ret, m_pc;
  bit            m_halt;

  task automatic m_reset();
    foreach (m_gp[i]) m_gp[i] = '0;
    foreach (m_sr[i]) m_sr[i] = '0;
    foreach (m_ar[i]) m_ar[i] = '0;
    m_ret = '0; m_pc = '0; m_halt = 0;
  endtask

  function automatic bit m_commit();
    return !m_halt && !bus.iw_flush && (bus.iw_opc != NOP);
  endfunction

  task automatic m_edge();
    if (m_commit()) begin
      if (bus.iw_tgt_gp_we) m_gp[bus.iw_tgt_gp] = bus.iw_result;
      if (bus.iw_tgt_sr_we) m_sr[bus.iw_tgt_sr] = bus.iw_sr_result;
      if (bus.iw_tgt_ar_we) m_ar[bus.iw_tgt_ar] = bus.iw_ar_result;
      m_ret = m_ret + 1;
      m_pc  = bus.iw_pc;
      if (bus.iw_opc == HALT) m_halt = 1;
    end
  endtask

  function automatic logic [DW-1:0] e_gp(input logic [GW-1:0] idx);
    if (m_commit() && bus.iw_tgt_gp_we && bus.iw_tgt_gp == idx) return bus.iw_result;
    return m_gp[idx];
  endfunction

  task automatic check_reads(input string tag);
    chk({tag, "_gp0"}, 64'(bus.ow_gp_rdata0), 64'(e_gp(bus.iw_gp_raddr0)));
    chk({tag, "_gp1"}, 64'(bus.ow_gp_rdata1), 64'(e_gp(bus.iw_gp_raddr1)));
    chk({tag, "_sr"}, 64'(bus.ow_sr_rdata),
        64'((m_commit() && bus.iw_tgt_sr_we && bus.iw_tgt_sr == bus.iw_sr_raddr)
            ? bus.iw_sr_result : m_sr[bus.iw_sr_raddr]));
    chk({tag, "_ar"}, 64'(bus.ow_ar_rdata),
        64'((m_commit() && bus.iw_tgt_ar_we && bus.iw_tgt_ar == bus.iw_ar_raddr)
            ? bus.iw_ar_result : m_ar[bus.iw_ar_raddr]));
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_retired"}, 64'(bus.ow_retired), 64'(m_ret));
    chk({tag, "_last_pc"}, 64'(bus.ow_last_pc), 64'(m_pc));
    chk({tag, "_halted"},  64'(bus.ow_halted),  64'(m_halt));
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic cycle(input string tag);
    #1 check_reads(tag);
    @(posedge clk);
    m_edge();
    #1 check_status(tag);
    @(negedge clk);
  endtask

  task automatic drv(input logic [OW-1:0] opc, input logic [AW-1:0] pc, input logic flush,
                     input logic gwe, input logic [GW-1:0] gi, input logic [DW-1:0] gd,
                     input logic swe, input logic [SW-1:0] si, input logic [AW-1:0] sd,
                     input logic awe, input logic [RW-1:0] ai, input logic [AW-1:0] ad);
    bus.iw_opc = opc; bus.iw_pc = pc; bus.iw_flush = flush;
    bus.iw_tgt_gp_we = gwe; bus.iw_tgt_gp = gi; bus.iw_result = gd;
    bus.iw_tgt_sr_we = swe; bus.iw_tgt_sr = si; bus.iw_sr_result = sd;
    bus.iw_tgt_ar_we = awe; bus.iw_tgt_ar = ai; bus.iw_ar_result = ad;
  endtask

  task automatic rd(input logic [GW-1:0] r0, input logic [GW-1:0] r1,
                    input logic [SW-1:0] rs, input logic [RW-1:0] ra);
    bus.iw_gp_raddr0 = r0; bus.iw_gp_raddr1 = r1; bus.iw_sr_raddr = rs; bus.iw_ar_raddr = ra;
  endtask

  task automatic idle();
    drv(NOP, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    #3;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int halted_cycles;
    idle();
    rd(0, 0, 0, 0);
    sbus.iw_pc = 8'h12; sbus.iw_opc = NOP; sbus.iw_flush = 1'b0;
    sbus.iw_tgt_gp = '0; sbus.iw_tgt_gp_we = 1'b0; sbus.iw_result = '0;
    sbus.iw_tgt_sr = '0; sbus.iw_tgt_sr_we = 1'b0; sbus.iw_sr_result = '0;
    sbus.iw_tgt_ar = '0; sbus.iw_tgt_ar_we = 1'b0; sbus.iw_ar_result = '0;
    sbus.iw_gp_raddr0 = '0; sbus.iw_gp_raddr1 = '0; sbus.iw_sr_raddr = '0; sbus.iw_ar_raddr = '0;
    m_reset();
    #12;
    check_status("reset");
    rd(5, 5, 1, 2);
    #1 check_reads("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Scenario 1: simple GP write, visible next cycle
    drv(8'h11, 48'd100, 1'b0, 1'b1, 4'd5, 24'hA1B2C3, 1'b0, '0, '0, 1'b0, '0, '0);
    rd(5, 0, 0, 0);
    cycle("s1_wr");
    idle();
    #1 chk("s1_gp5", 64'(bus.ow_gp_rdata0), 64'h0000_0000_00A1_B2C3);
    chk("s1_retired", 64'(bus.ow_retired), 64'd1);
    cycle("s1_rd");

    // Scenario 2: same-cycle bypass on port 1, port 0 sees stored value
    drv(8'h22, 48'd104, 1'b0, 1'b1, 4'd3, 24'h00C0DE, 1'b0, '0, '0, 1'b0, '0, '0);
    rd(4, 3, 0, 0);
    #1 chk("s2_bypass", 64'(bus.ow_gp_rdata1), 64'h00C0DE);
    chk("s2_old", 64'(bus.ow_gp_rdata0), 64'h0);
    cycle("s2");

    // Scenario 3: all three files in one commit
    drv(8'h33, 48'd108, 1'b0, 1'b1, 4'd6, 24'h5A5A5A,
        1'b1, 2'd1, 48'h123456789ABC, 1'b1, 2'd2, 48'hFEDCBA987654);
    rd(6, 3, 1, 2);
    cycle("s3_wr");
    idle();
    #1 chk("s3_sr1", 64'(bus.ow_sr_rdata), 64'h123456789ABC);
    chk("s3_ar2", 64'(bus.ow_ar_rdata), 64'hFEDCBA987654);
    chk("s3_gp6", 64'(bus.ow_gp_rdata0), 64'h5A5A5A);
    chk("s3_retired", 64'(bus.ow_retired), 64'd3);
    cycle("s3_rd");

    // Scenario 4: NOP and flush with enables set change nothing
    drv(NOP, 48'd200, 1'b0, 1'b1, 4'd6, 24'h111111, 1'b1, 2'd1, 48'h1, 1'b1, 2'd2, 48'h2);
    cycle("s4_nop");
    drv(8'h44, 48'd204, 1'b1, 1'b1, 4'd6, 24'h222222, 1'b1, 2'd1, 48'h3, 1'b1, 2'd2, 48'h4);
    cycle("s4_flush");
    drv(HALT, 48'd208, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    cycle("s4_flush_halt");
    idle();
    #1 chk("s4_gp6", 64'(bus.ow_gp_rdata0), 64'h5A5A5A);
    chk("s4_retired", 64'(bus.ow_retired), 64'd3);
    chk("s4_run", 64'(bus.ow_halted), 64'd0);

    // Scenario 5: HALT retires with its write, later writes are ignored
    drv(HALT, 48'd40, 1'b0, 1'b1, 4'd7, 24'h000123, 1'b0, '0, '0, 1'b0, '0, '0);
    rd(7, 6, 1, 2);
    cycle("s5_halt");
    chk("s5_halted", 64'(bus.ow_halted), 64'd1);
    chk("s5_last_pc", 64'(bus.ow_last_pc), 64'd40);
    drv(8'h55, 48'd44, 1'b0, 1'b1, 4'd7, 24'hBADBAD, 1'b1, 2'd1, 48'h9, 1'b1, 2'd2, 48'h9);
    #1 chk("s5_no_bypass", 64'(bus.ow_gp_rdata0), 64'h000123);
    cycle("s5_ignored");
    cycle("s5_ignored2");
    idle();
    do_reset();
    #1 chk("s5_reset_halted", 64'(bus.ow_halted), 64'd0);
    cycle("s5_after_reset");

    // Randomized traffic
    halted_cycles = 0;
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [OW-1:0] opc;
      r = $urandom_range(0, 99);
      opc = (r < 2) ? HALT : (r < 20) ? NOP : OW'($urandom_range(1, 254));
      drv(opc, {16'h0, 32'($urandom)}, ($urandom_range(0, 9) == 0),
          1'($urandom), GW'($urandom), DW'($urandom),
          1'($urandom), SW'($urandom), {16'($urandom), 32'($urandom)},
          1'($urandom), RW'($urandom), {16'($urandom), 32'($urandom)});
      rd(GW'($urandom), ($urandom_range(0, 2) == 0) ? bus.iw_tgt_gp : GW'($urandom),
         SW'($urandom), RW'($urandom));
      cycle("rnd");
      halted_cycles = m_halt ? halted_cycles + 1 : 0;
      if (halted_cycles > 8) begin
        idle();
        do_reset();
        halted_cycles = 0;
      end
    end

    // Counter wrap on the 8-bit instance
    idle();
    do_reset();
    sbus.iw_opc = 8'h01;
    repeat (255) @(negedge clk);
    chk("wrap_max", 64'(sbus.ow_retired), 64'hFF);
    @(negedge clk);
    chk("wrap_zero", 64'(sbus.ow_retired), 64'h0);
    chk("wrap_last_pc", 64'(sbus.ow_last_pc), 64'h12);
    sbus.iw_opc = NOP;

    // Async reset while a write is being presented
    drv(8'h66, 48'd300, 1'b0, 1'b1, 4'd9, 24'hABCDEF, 1'b1, 2'd3, 48'h7, 1'b1, 2'd0, 48'h8);
    rd(9, 6, 3, 0);
    cycle("ar_pre");
    drv(8'h66, 48'd304, 1'b0, 1'b1, 4'd10, 24'h777777, 1'b0, '0, '0, 1'b0, '0, '0);
    #2 rst_n = 1'b0;
    m_reset();
    #1 chk("ar_retired", 64'(bus.ow_retired), 64'd0);
    chk("ar_last_pc", 64'(bus.ow_last_pc), 64'd0);
    idle();
    for (int g = 0; g < 16; g++) begin
      rd(GW'(g), GW'(15 - g), SW'(g), RW'(g));
      #1 check_reads("ar_clear");
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle("ar_post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
